frame_reader: RTL and testbench

- Streams a 320x240 frame buffer, one 24-bit RGB pixel per address, in raster order.
- Pushes the pixels into a downstream display FIFO.
- Reads the frame memory through a synchronous port with 1-cycle read latency.
- Writes the FIFO with a we/full handshake and never loses or duplicates a pixel under backpressure.
- Sits between the frame-buffer RAM and the display/VGA FIFO.

---
 rtl/frame_reader.sv | 116 +++++++++++
 tb/tb_frame_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_reader.sv
// Raster-order frame-buffer reader feeding a display FIFO through a 2-entry skid buffer.
// Define FRAME_READER_SOF_EN to add the sof output, tagged through the buffer with each pixel.
module frame_reader #(
   parameter int DATA_W       = 24,
   parameter int ADDR_W       = 17,
   parameter int FRAME_PIXELS = 76800
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              full,
   input  logic [DATA_W-1:0] frame_data,
   output logic [ADDR_W-1:0] frame_addr,
   output logic              frame_re,
   output logic [DATA_W-1:0] data_out,
   output logic              we
`ifdef FRAME_READER_SOF_EN
   ,
   output logic              sof
`endif
);

   localparam int DEPTH = 2;
`ifdef FRAME_READER_SOF_EN
   localparam int ENT_W = DATA_W + 1;
`else
   localparam int ENT_W = DATA_W;
`endif

   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W-1:0] addr_next;
   logic [1:0]        occ_reg;
   logic [1:0]        occ_next;
   logic              inflight_reg;
   logic [ENT_W-1:0]  ent_reg  [DEPTH];
   logic [ENT_W-1:0]  ent_next [DEPTH];
   logic [ENT_W-1:0]  cap_word;
   logic [2:0]        level;
   logic [1:0]        cap_slot;
   logic              pop;
   logic              issue;
   logic              shift;

   // Entry 0 is always the head, so data_out keeps the last pixel when the buffer drains.
   assign pop      = rst_n & (occ_reg != 2'd0) & ~full;
   assign level    = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
   assign issue    = rst_n & (level < 3'd2);
   assign shift    = pop & (occ_reg == 2'd2);
   assign cap_slot = occ_reg - {1'b0, pop};
   assign occ_next = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};

   always_comb begin
      addr_next = addr_reg;
      if (issue) begin
         if (addr_reg == ADDR_W'(FRAME_PIXELS - 1)) begin
            addr_next = '0;
         end else begin
            addr_next = addr_reg + ADDR_W'(1);
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_ent
         logic [ENT_W-1:0] hold_val;
         if (gi < DEPTH - 1) begin : g_mid
            assign hold_val = shift ? ent_reg[gi+1] : ent_reg[gi];
         end else begin : g_tail
            assign hold_val = ent_reg[gi];
         end
         // Returning read data lands in the first slot left free after this cycle's pop.
         assign ent_next[gi] = (inflight_reg && (cap_slot == 2'(gi))) ? cap_word : hold_val;
      end
   endgenerate

`ifdef FRAME_READER_SOF_EN
   logic inflight_sof_reg;

   assign cap_word = {inflight_sof_reg, frame_data};
   assign sof      = we & ent_reg[0][DATA_W];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         inflight_sof_reg <= 1'b0;
      end else begin
         inflight_sof_reg <= issue & (addr_reg == '0);
      end
   end
`else
   assign cap_word = frame_data;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_reg     <= '0;
         occ_reg      <= 2'd0;
         inflight_reg <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_reg[i] <= '0;
         end
      end else begin
         addr_reg     <= addr_next;
         occ_reg      <= occ_next;
         inflight_reg <= issue;
         for (int i = 0; i < DEPTH; i++) begin
            ent_reg[i] <= ent_next[i];
         end
      end
   end

   assign frame_addr = addr_reg;
   assign frame_re   = issue;
   assign we         = pop;
   assign data_out   = ent_reg[0][DATA_W-1:0];

endmodule

// File: tb/tb_frame_reader.sv
// Bench for frame_reader: RAM returns mem[a]=a; the reference model expects the write stream 0,1,2,... modulo the frame size.
module tb_frame_reader;

   localparam int DATA_W   = 24;
   localparam int ADDR_W   = 17;
   localparam int N        = 76800;
   localparam int RST_ADDR = 5000;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              full = 1'b0;
   logic [DATA_W-1:0] frame_data = '0;
   logic [ADDR_W-1:0] frame_addr;
   logic              frame_re;
   logic [DATA_W-1:0] data_out;
   logic              we;
`ifdef FRAME_READER_SOF_EN
   logic              sof;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state
   int exp_addr = 0, exp_pix = 0, issued = 0, writes = 0, max_buf = 0;
   bit prev_re = 1'b0;
   int addr_err = 0, data_err = 0, wf_err = 0, sof_err = 0, rst_err = 0;
   int addr_bad_got = 0, addr_bad_exp = 0, data_bad_got = 0, data_bad_exp = 0;

   frame_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FRAME_PIXELS(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .full       (full),
      .frame_data (frame_data),
      .frame_addr (frame_addr),
      .frame_re   (frame_re),
      .data_out   (data_out),
      .we         (we)
`ifdef FRAME_READER_SOF_EN
      ,
      .sof        (sof)
`endif
   );

   always #5 clk = ~clk;

   // Frame RAM with one cycle of read latency, contents mem[a] = a.
   always @(posedge clk) begin
      if (frame_re === 1'b1) frame_data <= DATA_W'(frame_addr);
   end

   task automatic clear_errs();
      addr_err = 0; data_err = 0; wf_err = 0; sof_err = 0; rst_err = 0; max_buf = 0;
   endtask

   // One clock: drive inputs on the falling edge, observe settled outputs, advance the model.
   task automatic tick(input logic f, input logic r);
      int buffered;
      @(negedge clk);
      full = f;
      rst_n = r;
      #1;
      if (!rst_n) begin
         if (we !== 1'b0 || frame_re !== 1'b0) rst_err++;
         exp_addr = 0; exp_pix = 0; issued = 0; writes = 0; prev_re = 1'b0;
      end else begin
         buffered = issued - (prev_re ? 1 : 0) - writes;
         if (buffered > max_buf) max_buf = buffered;
         if (frame_re === 1'b1) begin
            if (frame_addr !== ADDR_W'(exp_addr)) begin
               addr_err++; addr_bad_got = int'(frame_addr); addr_bad_exp = exp_addr;
            end
            exp_addr = (exp_addr + 1) % N;
            issued++;
         end
         if (we === 1'b1) begin
            if (full) wf_err++;
            if (data_out !== DATA_W'(exp_pix)) begin
               data_err++; data_bad_got = int'(data_out); data_bad_exp = exp_pix;
            end
`ifdef FRAME_READER_SOF_EN
            if (sof !== (exp_pix == 0)) sof_err++;
`endif
            exp_pix = (exp_pix + 1) % N;
            writes++;
         end else begin
`ifdef FRAME_READER_SOF_EN
            if (sof !== 1'b0) sof_err++;
`endif
         end
         prev_re = (frame_re === 1'b1);
      end
   endtask

   task automatic test_reset();
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tests_run++;
      if (frame_re !== 1'b0 || we !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got re=%b we=%b, expected re=0 we=0", frame_re, we);
      end
      tests_run++;
      if (data_out !== '0) begin
         tests_failed++;
         $display("FAIL reset_data_out: got %0d, expected 0", data_out);
      end
`ifdef FRAME_READER_SOF_EN
      tests_run++;
      if (sof !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_sof: got %b, expected 0", sof);
      end
`endif
   endtask

   task automatic test_free_run();
      int bubbles = 0;
      clear_errs();
      tick(1'b0, 1'b1);
      tests_run++;
      if (frame_re !== 1'b1 || frame_addr !== '0 || we !== 1'b0) begin
         tests_failed++;
         $display("FAIL first_issue: got re=%b addr=%0d we=%b, expected re=1 addr=0 we=0", frame_re, frame_addr, we);
      end
      tick(1'b0, 1'b1);
      tests_run++;
      if (we !== 1'b0) begin
         tests_failed++;
         $display("FAIL early_write: got we=%b, expected 0", we);
      end
      tick(1'b0, 1'b1);
      tests_run++;
      if (we !== 1'b1 || data_out !== '0) begin
         tests_failed++;
         $display("FAIL first_write: got we=%b data=%0d, expected we=1 data=0", we, data_out);
      end
      for (int i = 0; i < 60; i++) begin
         tick(1'b0, 1'b1);
         if (we !== 1'b1 || frame_re !== 1'b1) bubbles++;
      end
      tests_run++;
      if (bubbles !== 0) begin
         tests_failed++;
         $display("FAIL free_run_bubbles: got %0d idle cycles, expected 0", bubbles);
      end
      tests_run++;
      if (data_err !== 0 || addr_err !== 0) begin
         tests_failed++;
         $display("FAIL free_run_stream: got %0d data (last %0d vs %0d) and %0d addr errors, expected 0",
                  data_err, data_bad_got, data_bad_exp, addr_err);
      end
   endtask

   task automatic test_backpressure();
      int we_cnt = 0, re_late = 0, hold_err = 0;
      clear_errs();
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 1'b1);
         if (we !== 1'b0) we_cnt++;
         if (i >= 1 && frame_re !== 1'b0) re_late++;
         if (data_out !== DATA_W'(exp_pix)) hold_err++;
      end
      tests_run++;
      if (we_cnt !== 0) begin
         tests_failed++;
         $display("FAIL bp_we_while_full: got %0d writes, expected 0", we_cnt);
      end
      tests_run++;
      if (re_late !== 0) begin
         tests_failed++;
         $display("FAIL bp_issue_stop: got %0d late reads, expected 0", re_late);
      end
      tests_run++;
      if (hold_err !== 0) begin
         tests_failed++;
         $display("FAIL bp_data_hold: got %0d cycles with data_out != %0d, expected 0", hold_err, exp_pix);
      end
      tick(1'b0, 1'b1);
      tests_run++;
      if (we !== 1'b1) begin
         tests_failed++;
         $display("FAIL bp_release_we: got we=%b, expected 1", we);
      end
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
      tests_run++;
      if (data_err !== 0 || max_buf > 2) begin
         tests_failed++;
         $display("FAIL bp_resume_stream: got %0d data errors (last %0d vs %0d), max buffered %0d, expected 0 and <=2",
                  data_err, data_bad_got, data_bad_exp, max_buf);
      end
   endtask

   task automatic test_random_full();
      int wr = 0;
      clear_errs();
      for (int i = 0; i < 3000; i++) begin
         tick(1'($urandom_range(0, 1)), 1'b1);
         if (we === 1'b1) wr++;
      end
      tests_run++;
      if (wf_err !== 0) begin
         tests_failed++;
         $display("FAIL rand_we_with_full: got %0d, expected 0", wf_err);
      end
      tests_run++;
      if (data_err !== 0 || addr_err !== 0) begin
         tests_failed++;
         $display("FAIL rand_stream: got %0d data (last %0d vs %0d), %0d addr (last %0d vs %0d) errors, expected 0",
                  data_err, data_bad_got, data_bad_exp, addr_err, addr_bad_got, addr_bad_exp);
      end
      tests_run++;
      if (max_buf > 2 || wr < 1000) begin
         tests_failed++;
         $display("FAIL rand_progress: got max buffered %0d, %0d writes, expected <=2 and >=1000", max_buf, wr);
      end
   endtask

   task automatic test_reset_mid_frame();
      bit found = 1'b0;
      clear_errs();
      for (int i = 0; i < 10000 && !found; i++) begin
         tick(1'b0, 1'b1);
         if (frame_re === 1'b1 && frame_addr === ADDR_W'(RST_ADDR)) found = 1'b1;
      end
      tests_run++;
      if (!found) begin
         tests_failed++;
         $display("FAIL mid_reach_addr: address %0d not issued within budget", RST_ADDR);
      end
      tick(1'b0, 1'b0);
      tests_run++;
      if (we !== 1'b0 || frame_re !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_reset_outputs: got we=%b re=%b, expected 0 0", we, frame_re);
      end
      tick(1'b0, 1'b1);
      tests_run++;
      if (frame_re !== 1'b1 || frame_addr !== '0 || we !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_restart_issue: got re=%b addr=%0d we=%b, expected re=1 addr=0 we=0", frame_re, frame_addr, we);
      end
      tick(1'b0, 1'b1);
      tests_run++;
      if (we !== 1'b0) begin
         tests_failed++;
         $display("FAIL mid_stale_write: got we=%b data=%0d, expected we=0", we, data_out);
      end
      tick(1'b0, 1'b1);
      tests_run++;
      if (we !== 1'b1 || data_out !== '0) begin
         tests_failed++;
         $display("FAIL mid_first_write: got we=%b data=%0d, expected we=1 data=0", we, data_out);
      end
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b1);
      tests_run++;
      if (data_err !== 0 || rst_err !== 0) begin
         tests_failed++;
         $display("FAIL mid_stream: got %0d data errors (last %0d vs %0d), %0d reset errors, expected 0",
                  data_err, data_bad_got, data_bad_exp, rst_err);
      end
   endtask

   task automatic test_stall_at_start();
      int we_cnt = 0;
      clear_errs();
      tick(1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick(1'b1, 1'b1);
         if (we !== 1'b0) we_cnt++;
      end
      tick(1'b0, 1'b1);
      tests_run++;
      if (we_cnt !== 0 || we !== 1'b1 || data_out !== '0) begin
         tests_failed++;
         $display("FAIL stall_start: got %0d stalled writes, we=%b data=%0d, expected 0, 1, 0", we_cnt, we, data_out);
      end
`ifdef FRAME_READER_SOF_EN
      tests_run++;
      if (sof !== 1'b1) begin
         tests_failed++;
         $display("FAIL stall_start_sof: got %b, expected 1", sof);
      end
`endif
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1);
      tests_run++;
      if (data_err !== 0 || sof_err !== 0) begin
         tests_failed++;
         $display("FAIL stall_start_stream: got %0d data, %0d sof errors, expected 0", data_err, sof_err);
      end
   endtask

   task automatic test_wrap();
      int wr = 0, bubbles = 0, last_cyc = -10, sof_cnt = 0;
      bit wrap_ok = 1'b0;
      clear_errs();
      tick(1'b0, 1'b0);
      for (int c = 0; c < 76850; c++) begin
         tick(1'b0, 1'b1);
         if (frame_re !== 1'b1) bubbles++;
         if (we === 1'b1) begin
            wr++;
            if (data_out === DATA_W'(N - 1)) last_cyc = c;
            if (data_out === '0 && c == last_cyc + 1) wrap_ok = 1'b1;
`ifdef FRAME_READER_SOF_EN
            if (sof === 1'b1) sof_cnt++;
`endif
         end
      end
      tests_run++;
      if (wr !== 76848) begin
         tests_failed++;
         $display("FAIL wrap_write_count: got %0d, expected 76848", wr);
      end
      tests_run++;
      if (bubbles !== 0 || addr_err !== 0) begin
         tests_failed++;
         $display("FAIL wrap_addr_seq: got %0d bubbles, %0d addr errors (last %0d vs %0d), expected 0",
                  bubbles, addr_err, addr_bad_got, addr_bad_exp);
      end
      tests_run++;
      if (!wrap_ok || data_err !== 0) begin
         tests_failed++;
         $display("FAIL wrap_data: got wrap_ok=%0d, %0d data errors (last %0d vs %0d), expected 1 and 0",
                  wrap_ok, data_err, data_bad_got, data_bad_exp);
      end
`ifdef FRAME_READER_SOF_EN
      tests_run++;
      if (sof_cnt !== 2 || sof_err !== 0) begin
         tests_failed++;
         $display("FAIL wrap_sof: got %0d pulses, %0d errors, expected 2 and 0", sof_cnt, sof_err);
      end
`endif
   endtask

   initial begin
      test_reset();
      test_free_run();
      test_backpressure();
      test_random_full();
      test_reset_mid_frame();
      test_stall_at_start();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
